router_ctrl_fsm: RTL and testbench
==================================

ROUTER_CTRL_FSM -- requirements
Module: router_ctrl_fsm

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of output channels (2..2**ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 2, address field width (low bits of header byte).
REQ-003 SHALL have parameter WAIT_TIMEOUT, default 64, max cycles in WAIT_TILL_EMPTY before drop; 0 disables timeout.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 pkt_valid  in  1  source packet valid.
REQ-007 data_in  in  ADDR_W  destination address bits of header byte.
REQ-008 fifo_full  in  1  full flag of selected channel FIFO.
REQ-009 empty  in  NUM_CH  per-channel FIFO empty flags.
REQ-010 soft_reset  in  NUM_CH  per-channel soft reset (read timeout).
REQ-011 parity_done  in  1  parity byte written by register block.
REQ-012 low_pkt_valid  in  1  pkt_valid fell while FIFO was full.
REQ-013 write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy  out  1 each  state decodes per REQ-020.
REQ-014 addr_out  out  ADDR_W  latched destination address.
REQ-015 drop_state  out  1  packet being discarded.
REQ-016 timeout_err  out  1  one-cycle pulse on wait timeout.

Function
REQ-017 States SHALL be: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR, DROP_PACKET.
REQ-018 addr_out SHALL load data_in on the clk edge where state=DECODE_ADDRESS and pkt_valid=1; held otherwise.
REQ-019 Transitions (evaluated each rising clk, registered state):
- DECODE: pkt_valid & data_in>=NUM_CH -> DROP; pkt_valid & empty[data_in] -> LFD; pkt_valid & !empty[data_in] -> WAIT; else stay.
- LFD -> LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full -> FULL; !fifo_full & !pkt_valid -> LOAD_PARITY; else stay.
- FULL: !fifo_full -> LAF; else stay.
- LAF: parity_done -> DECODE; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FULL; else -> DECODE.
- WAIT: empty[addr_out] -> LFD; else wait counter==WAIT_TIMEOUT-1 (WAIT_TIMEOUT>0) -> DROP with timeout_err=1 that cycle+1 only; else stay.
- DROP: !pkt_valid -> DECODE; else stay.
REQ-020 Moore outputs: detect_add=DECODE; lfd_state=LFD; ld_state=LOAD_DATA; laf_state=LAF; full_state=FULL; rst_int_reg=CHECK_PARITY_ERROR; drop_state=DROP; write_enb_reg=LOAD_DATA|LOAD_PARITY|LAF; busy=1 in LFD, LOAD_PARITY, FULL, LAF, WAIT, CHECK_PARITY_ERROR, else 0.
REQ-021 soft_reset[addr_out]=1 in any state other than DECODE or DROP SHALL force DECODE next cycle, overriding REQ-019; soft_reset of other channels ignored.
REQ-022 Wait counter SHALL clear on entry to WAIT and whenever not in WAIT; width clog2(WAIT_TIMEOUT+1); no wrap (saturates if disabled).
REQ-023 When empty[addr_out] and timeout coincide, LFD SHALL win (no timeout_err).
REQ-024 Soft reset and timeout coinciding in WAIT: DECODE wins, no timeout_err.
REQ-025 DROP_PACKET SHALL keep busy=0 and write_enb_reg=0 so source drains packet unwritten.

Reset
REQ-026 resetn=0 SHALL immediately force DECODE_ADDRESS, addr_out=0, wait counter=0, timeout_err=0; outputs then detect_add=1, all others 0, regardless of clock.
REQ-027 Reset asserted mid-packet SHALL abort the packet; no further write_enb_reg until a new header is decoded.

Verification
REQ-028 Addr 1, empty=3'b111, pkt_valid high 14 cycles then low, fifo_full=0 -> DECODE, LFD, 14x LOAD_DATA, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE; write_enb_reg high 15 cycles.
REQ-029 Addr 0, 16-byte payload, fifo_full=1 for 3 cycles mid-payload, low_pkt_valid=0 -> FULL held 3 cycles, busy=1, LAF, back to LOAD_DATA; later pkt_valid drop reaches LOAD_PARITY.
REQ-030 Addr 2, 18-byte payload, fifo_full rises in LOAD_DATA with pkt_valid falling, low_pkt_valid=1 -> FULL, LAF, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE.
REQ-031 Addr 3 with NUM_CH=3 -> DROP, drop_state=1, busy=0, write_enb_reg=0 until pkt_valid low, then DECODE.
REQ-032 Addr 1, empty[1]=0 held, WAIT_TIMEOUT=8 -> WAIT for 8 cycles, timeout_err single pulse, DROP; repeat with empty[1]=1 at cycle 8 -> LFD, no pulse.
REQ-033 soft_reset[addr_out]=1 in LOAD_DATA -> DECODE next cycle; soft_reset of other channel -> no effect; resetn=0 mid-FULL -> detect_add=1 asynchronously.

Source files
------------

// File: rtl/router_ctrl_fsm_if.sv
// Router control bus: packet source, FIFO status and FSM state decodes.
interface router_ctrl_fsm_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              parity_done;
  logic              low_pkt_valid;

  logic              write_enb_reg;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              busy;
  logic [ADDR_W-1:0] addr_out;
  logic              drop_state;
  logic              timeout_err;

  // Controller side
  modport slave (
    input  pkt_valid, data_in, fifo_full, empty, soft_reset, parity_done, low_pkt_valid,
    output write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, busy, addr_out, drop_state, timeout_err
  );

  // Environment side (source, FIFOs, register block)
  modport master (
    output pkt_valid, data_in, fifo_full, empty, soft_reset, parity_done, low_pkt_valid,
    input  write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, busy, addr_out, drop_state, timeout_err
  );
endinterface

// File: rtl/router_ctrl_fsm.sv
// Router control FSM: decodes the header address, sequences payload/parity
// writes, stalls on full FIFOs, waits for a busy channel and drops bad or
// timed-out packets. All outputs are registered Moore decodes of the state.
module router_ctrl_fsm #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  router_ctrl_fsm_if.slave  bus
);

  localparam int NSEL  = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [ADDR_W:0]  LP_NUM_CH   = (ADDR_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_DECODE_ADDRESS,
    S_LOAD_FIRST_DATA,
    S_LOAD_DATA,
    S_LOAD_PARITY,
    S_FIFO_FULL_STATE,
    S_LOAD_AFTER_FULL,
    S_WAIT_TILL_EMPTY,
    S_CHECK_PARITY_ERROR,
    S_DROP_PACKET
  } state_t;

  state_t            r_state;
  state_t            w_nxt_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_timeout_err;
  logic              r_write_enb_reg;
  logic              r_detect_add;
  logic              r_lfd_state;
  logic              r_ld_state;
  logic              r_laf_state;
  logic              r_full_state;
  logic              r_rst_int_reg;
  logic              r_busy;
  logic              r_drop_state;

  // Flags padded to the full address space so any address indexes safely;
  // channels beyond NUM_CH read as not-empty / no soft reset.
  logic [NSEL-1:0]   w_empty_pad;
  logic [NSEL-1:0]   w_soft_pad;
  logic              w_hdr_empty;
  logic              w_hdr_bad;
  logic              w_sel_empty;
  logic              w_sel_soft;
  logic              w_wait_expired;
  logic              w_timeout;

  assign w_empty_pad    = NSEL'(bus.empty);
  assign w_soft_pad     = NSEL'(bus.soft_reset);
  assign w_hdr_empty    = w_empty_pad[bus.data_in];
  assign w_hdr_bad      = ({1'b0, bus.data_in} >= LP_NUM_CH);
  assign w_sel_empty    = w_empty_pad[r_addr];
  assign w_sel_soft     = w_soft_pad[r_addr];
  assign w_wait_expired = (WAIT_TIMEOUT > 0) && (r_wait_cnt == LP_CNT_LAST);

  // Next-state selection; a soft reset on the active channel overrides all
  // transitions (and suppresses a coincident timeout) outside DECODE/DROP.
  always_comb begin
    w_nxt_state = r_state;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_DECODE_ADDRESS: begin
        if (bus.pkt_valid) begin
          if (w_hdr_bad)        w_nxt_state = S_DROP_PACKET;
          else if (w_hdr_empty) w_nxt_state = S_LOAD_FIRST_DATA;
          else                  w_nxt_state = S_WAIT_TILL_EMPTY;
        end
      end
      S_LOAD_FIRST_DATA: w_nxt_state = S_LOAD_DATA;
      S_LOAD_DATA: begin
        if (bus.fifo_full)       w_nxt_state = S_FIFO_FULL_STATE;
        else if (!bus.pkt_valid) w_nxt_state = S_LOAD_PARITY;
      end
      S_FIFO_FULL_STATE: begin
        if (!bus.fifo_full) w_nxt_state = S_LOAD_AFTER_FULL;
      end
      S_LOAD_AFTER_FULL: begin
        if (bus.parity_done)        w_nxt_state = S_DECODE_ADDRESS;
        else if (bus.low_pkt_valid) w_nxt_state = S_LOAD_PARITY;
        else                        w_nxt_state = S_LOAD_DATA;
      end
      S_LOAD_PARITY: w_nxt_state = S_CHECK_PARITY_ERROR;
      S_CHECK_PARITY_ERROR: begin
        if (bus.fifo_full) w_nxt_state = S_FIFO_FULL_STATE;
        else               w_nxt_state = S_DECODE_ADDRESS;
      end
      S_WAIT_TILL_EMPTY: begin
        if (w_sel_empty) begin
          w_nxt_state = S_LOAD_FIRST_DATA;
        end else if (w_wait_expired) begin
          w_nxt_state = S_DROP_PACKET;
          w_timeout   = 1'b1;
        end
      end
      S_DROP_PACKET: begin
        if (!bus.pkt_valid) w_nxt_state = S_DECODE_ADDRESS;
      end
      default: w_nxt_state = S_DECODE_ADDRESS;
    endcase
    if (w_sel_soft && (r_state != S_DECODE_ADDRESS) && (r_state != S_DROP_PACKET)) begin
      w_nxt_state = S_DECODE_ADDRESS;
      w_timeout   = 1'b0;
    end
  end

  // State, address latch, wait counter and registered Moore decodes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_DECODE_ADDRESS;
      r_addr          <= '0;
      r_wait_cnt      <= '0;
      r_timeout_err   <= 1'b0;
      r_detect_add    <= 1'b1;
      r_lfd_state     <= 1'b0;
      r_ld_state      <= 1'b0;
      r_laf_state     <= 1'b0;
      r_full_state    <= 1'b0;
      r_rst_int_reg   <= 1'b0;
      r_drop_state    <= 1'b0;
      r_write_enb_reg <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      if ((r_state == S_DECODE_ADDRESS) && bus.pkt_valid) r_addr <= bus.data_in;
      if ((r_state == S_WAIT_TILL_EMPTY) && (w_nxt_state == S_WAIT_TILL_EMPTY))
        r_wait_cnt <= (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + 1'b1;
      else
        r_wait_cnt <= '0;
      r_timeout_err   <= w_timeout;
      r_detect_add    <= (w_nxt_state == S_DECODE_ADDRESS);
      r_lfd_state     <= (w_nxt_state == S_LOAD_FIRST_DATA);
      r_ld_state      <= (w_nxt_state == S_LOAD_DATA);
      r_laf_state     <= (w_nxt_state == S_LOAD_AFTER_FULL);
      r_full_state    <= (w_nxt_state == S_FIFO_FULL_STATE);
      r_rst_int_reg   <= (w_nxt_state == S_CHECK_PARITY_ERROR);
      r_drop_state    <= (w_nxt_state == S_DROP_PACKET);
      r_write_enb_reg <= (w_nxt_state inside {S_LOAD_DATA, S_LOAD_PARITY, S_LOAD_AFTER_FULL});
      r_busy          <= (w_nxt_state inside {S_LOAD_FIRST_DATA, S_LOAD_PARITY, S_FIFO_FULL_STATE,
                                              S_LOAD_AFTER_FULL, S_WAIT_TILL_EMPTY,
                                              S_CHECK_PARITY_ERROR});
    end
  end

  assign bus.write_enb_reg = r_write_enb_reg;
  assign bus.detect_add    = r_detect_add;
  assign bus.lfd_state     = r_lfd_state;
  assign bus.ld_state      = r_ld_state;
  assign bus.laf_state     = r_laf_state;
  assign bus.full_state    = r_full_state;
  assign bus.rst_int_reg   = r_rst_int_reg;
  assign bus.busy          = r_busy;
  assign bus.addr_out      = r_addr;
  assign bus.drop_state    = r_drop_state;
  assign bus.timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm: walks each packet scenario edge by
// edge and compares the packed state decodes against hand-derived values.
module tb_router_ctrl_fsm;

  localparam int NUM_CH       = 3;
  localparam int ADDR_W       = 2;
  localparam int WAIT_TIMEOUT = 8;

  // Packed decode order: detect_add lfd ld laf full rst_int drop write_enb busy
  localparam logic [8:0] E_DEC  = 9'b100000000;
  localparam logic [8:0] E_LFD  = 9'b010000001;
  localparam logic [8:0] E_LD   = 9'b001000010;
  localparam logic [8:0] E_LAF  = 9'b000100011;
  localparam logic [8:0] E_FULL = 9'b000010001;
  localparam logic [8:0] E_LP   = 9'b000000011;
  localparam logic [8:0] E_CPE  = 9'b000001001;
  localparam logic [8:0] E_DROP = 9'b000000100;
  localparam logic [8:0] E_WAIT = 9'b000000001;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  router_ctrl_fsm_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_if ();

  router_ctrl_fsm #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (u_if)
  );

  logic [8:0] w_outs;
  assign w_outs = {u_if.detect_add, u_if.lfd_state, u_if.ld_state, u_if.laf_state,
                   u_if.full_state, u_if.rst_int_reg, u_if.drop_state,
                   u_if.write_enb_reg, u_if.busy};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge, then sample decodes and the timeout pulse 1 ns later.
  task automatic step(input string tag, input logic [8:0] exp, input logic exp_to);
    @(posedge clk);
    #1;
    check(tag, 32'(w_outs), 32'(exp));
    check({tag, "_to"}, 32'(u_if.timeout_err), 32'(exp_to));
  endtask

  initial begin
    resetn             = 1'b1;
    u_if.pkt_valid     = 1'b0;
    u_if.data_in       = '0;
    u_if.fifo_full     = 1'b0;
    u_if.empty         = '1;
    u_if.soft_reset    = '0;
    u_if.parity_done   = 1'b0;
    u_if.low_pkt_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("rst_outs", 32'(w_outs), 32'(E_DEC));
    check("rst_addr", 32'(u_if.addr_out), 32'd0);
    check("rst_to", 32'(u_if.timeout_err), 32'd0);
    #1 resetn = 1'b1;
    step("idle", E_DEC, 1'b0);

    // Addr 1, clean packet: LFD, 14 x LOAD_DATA, parity, check, decode
    u_if.data_in = 2'd1; u_if.pkt_valid = 1'b1;
    step("t1_lfd", E_LFD, 1'b0);
    check("t1_addr", 32'(u_if.addr_out), 32'd1);
    step("t1_ld0", E_LD, 1'b0);
    for (int i = 0; i < 13; i++) step("t1_ld", E_LD, 1'b0);
    u_if.pkt_valid = 1'b0;
    step("t1_lp", E_LP, 1'b0);
    step("t1_cpe", E_CPE, 1'b0);
    step("t1_dec", E_DEC, 1'b0);

    // Addr 0, FIFO full for 3 cycles mid-payload
    u_if.data_in = 2'd0; u_if.pkt_valid = 1'b1;
    step("t2_lfd", E_LFD, 1'b0);
    check("t2_addr", 32'(u_if.addr_out), 32'd0);
    for (int i = 0; i < 5; i++) step("t2_ld", E_LD, 1'b0);
    u_if.fifo_full = 1'b1;
    step("t2_full1", E_FULL, 1'b0);
    step("t2_full2", E_FULL, 1'b0);
    step("t2_full3", E_FULL, 1'b0);
    u_if.fifo_full = 1'b0;
    step("t2_laf", E_LAF, 1'b0);
    step("t2_ld_back", E_LD, 1'b0);
    step("t2_ld_more", E_LD, 1'b0);
    u_if.pkt_valid = 1'b0;
    step("t2_lp", E_LP, 1'b0);
    step("t2_cpe", E_CPE, 1'b0);
    step("t2_dec", E_DEC, 1'b0);

    // Addr 2, full with pkt_valid falling, low_pkt_valid routes LAF to parity
    u_if.data_in = 2'd2; u_if.pkt_valid = 1'b1;
    step("t3_lfd", E_LFD, 1'b0);
    step("t3_ld", E_LD, 1'b0);
    step("t3_ld2", E_LD, 1'b0);
    u_if.fifo_full = 1'b1; u_if.pkt_valid = 1'b0; u_if.low_pkt_valid = 1'b1;
    step("t3_full", E_FULL, 1'b0);
    u_if.fifo_full = 1'b0;
    step("t3_laf", E_LAF, 1'b0);
    step("t3_lp", E_LP, 1'b0);
    u_if.low_pkt_valid = 1'b0;
    step("t3_cpe", E_CPE, 1'b0);
    step("t3_dec", E_DEC, 1'b0);

    // Full during parity check, then parity_done ends the packet from LAF
    u_if.data_in = 2'd1; u_if.pkt_valid = 1'b1;
    step("t4_lfd", E_LFD, 1'b0);
    step("t4_ld", E_LD, 1'b0);
    u_if.pkt_valid = 1'b0;
    step("t4_lp", E_LP, 1'b0);
    u_if.fifo_full = 1'b1;
    step("t4_cpe", E_CPE, 1'b0);
    step("t4_full", E_FULL, 1'b0);
    u_if.fifo_full = 1'b0; u_if.parity_done = 1'b1;
    step("t4_laf", E_LAF, 1'b0);
    step("t4_dec", E_DEC, 1'b0);
    u_if.parity_done = 1'b0;

    // Addr 3 is out of range with 3 channels: drop until pkt_valid falls
    u_if.data_in = 2'd3; u_if.pkt_valid = 1'b1;
    step("t5_drop", E_DROP, 1'b0);
    check("t5_addr", 32'(u_if.addr_out), 32'd3);
    step("t5_drop2", E_DROP, 1'b0);
    step("t5_drop3", E_DROP, 1'b0);
    u_if.pkt_valid = 1'b0;
    step("t5_dec", E_DEC, 1'b0);

    // Channel 1 never drains: 8 cycles in WAIT, single timeout pulse, drop
    u_if.data_in = 2'd1; u_if.empty = 3'b101; u_if.pkt_valid = 1'b1;
    step("t6_wait0", E_WAIT, 1'b0);
    for (int i = 0; i < 7; i++) step("t6_wait", E_WAIT, 1'b0);
    step("t6_drop", E_DROP, 1'b1);
    step("t6_drop2", E_DROP, 1'b0);
    u_if.pkt_valid = 1'b0;
    step("t6_dec", E_DEC, 1'b0);

    // Channel drains on the last wait cycle: LFD wins, no pulse
    u_if.pkt_valid = 1'b1;
    step("t7_wait0", E_WAIT, 1'b0);
    for (int i = 0; i < 7; i++) step("t7_wait", E_WAIT, 1'b0);
    u_if.empty = 3'b111;
    step("t7_lfd", E_LFD, 1'b0);
    step("t7_ld", E_LD, 1'b0);
    u_if.soft_reset = 3'b001;
    step("t7_soft_other", E_LD, 1'b0);
    u_if.soft_reset = 3'b010; u_if.pkt_valid = 1'b0;
    step("t7_soft_own", E_DEC, 1'b0);
    // Soft reset is ignored while decoding, then aborts LFD
    u_if.pkt_valid = 1'b1;
    step("t7_soft_dec", E_LFD, 1'b0);
    u_if.pkt_valid = 1'b0;
    step("t7_soft_lfd", E_DEC, 1'b0);
    u_if.soft_reset = '0;

    // Soft reset coinciding with timeout: decode, no pulse
    u_if.empty = 3'b101; u_if.pkt_valid = 1'b1;
    step("t8_wait0", E_WAIT, 1'b0);
    for (int i = 0; i < 7; i++) step("t8_wait", E_WAIT, 1'b0);
    u_if.soft_reset = 3'b010; u_if.pkt_valid = 1'b0;
    step("t8_dec", E_DEC, 1'b0);
    u_if.soft_reset = '0;
    step("t8_idle", E_DEC, 1'b0);

    // Asynchronous reset while stalled on a full FIFO
    u_if.empty = 3'b111; u_if.data_in = 2'd2; u_if.pkt_valid = 1'b1;
    step("t9_lfd", E_LFD, 1'b0);
    step("t9_ld", E_LD, 1'b0);
    u_if.fifo_full = 1'b1;
    step("t9_full", E_FULL, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check("t9_async_outs", 32'(w_outs), 32'(E_DEC));
    check("t9_async_addr", 32'(u_if.addr_out), 32'd0);
    u_if.pkt_valid = 1'b0; u_if.fifo_full = 1'b0;
    resetn = 1'b1;
    step("t9_post1", E_DEC, 1'b0);
    step("t9_post2", E_DEC, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
